// File: rtl/loader_pkg.sv
// Shared types and constants for the program-load receive engine.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_AA,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] ACK_OK    = 8'hAA;
  localparam logic [7:0] ACK_ERR   = 8'h55;
  localparam int         LEN_BYTES = 4;

  function automatic logic [7:0] ack_byte(input logic ok);
    return ok ? ACK_OK : ACK_ERR;
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Big-endian byte-to-word assembler; the word and its strobe appear combinationally
// with the final byte so the loader can register the write one cycle later.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'(LEN_BYTES - 1));

endmodule

// File: rtl/instr_loader.sv
// Program-load receive engine: length word, instruction words, optional XOR checksum.
// Optional checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader
  import loader_pkg::*;
#(
  parameter int INST_SIZE = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 aa_sent_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 rx_ferr_i,
  output logic                 imem_we_o,
  output logic [INST_SIZE-1:0] imem_addr_o,
  output logic [31:0]          imem_wdata_o,
  output logic [INST_SIZE:0]   inst_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 ack_valid_o,
  output logic [7:0]           ack_data_o
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << INST_SIZE;

  loader_state_t        state_q;
  logic [INST_SIZE:0]   len_q;
  logic [INST_SIZE:0]   inst_count_q;
  logic [INST_SIZE:0]   inst_count_d;
  logic                 imem_we_q;
  logic [INST_SIZE-1:0] imem_addr_q;
  logic [31:0]          imem_wdata_q;
  logic                 done_q;
  logic                 err_q;
  logic                 ack_valid_q;
  logic [7:0]           ack_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  logic        in_rx_phase;
  logic        asm_valid;
  logic        asm_clr;
  logic        bad_byte;
  logic        word_valid;
  logic [31:0] word;
  logic        len_too_big;
  logic        len_zero;

  // Only LEN and DATA feed the assembler; CSUM bytes bypass it.
  assign in_rx_phase  = (state_q == LEN) || (state_q == DATA);
  assign asm_valid    = start_i && rx_valid_i && !rx_ferr_i && in_rx_phase;
  assign asm_clr      = !start_i || (state_q == IDLE);
  assign bad_byte     = rx_valid_i && rx_ferr_i &&
                        (in_rx_phase || (state_q == CSUM));
  assign inst_count_d = inst_count_q + 1'b1;
  assign len_too_big  = {1'b0, word} > MAX_WORDS;
  assign len_zero     = (word == 32'd0);

  word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      inst_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ack_valid_q  <= 1'b0;
      ack_data_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_q   <= 1'b0;
      ack_valid_q <= 1'b0;
      if (!start_i) begin
        state_q      <= IDLE;
        len_q        <= '0;
        inst_count_q <= '0;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end else if (bad_byte) begin
        state_q     <= ERR;
        err_q       <= 1'b1;
        ack_valid_q <= 1'b1;
        ack_data_q  <= ack_byte(1'b0);
      end else begin
        case (state_q)
          IDLE: begin
            state_q      <= WAIT_AA;
            inst_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
          WAIT_AA: begin
            if (aa_sent_i) state_q <= LEN;
          end
          LEN: begin
            if (word_valid) begin
              len_q <= word[INST_SIZE:0];
              if (len_too_big) begin
                state_q     <= ERR;
                err_q       <= 1'b1;
                ack_valid_q <= 1'b1;
                ack_data_q  <= ack_byte(1'b0);
              end else if (len_zero) begin
`ifdef LOADER_CHECKSUM_EN
                state_q     <= CSUM;
`else
                state_q     <= DONE;
                done_q      <= 1'b1;
                ack_valid_q <= 1'b1;
                ack_data_q  <= ack_byte(1'b1);
`endif
              end else begin
                state_q <= DATA;
              end
            end
          end
          DATA: begin
`ifdef LOADER_CHECKSUM_EN
            if (rx_valid_i) csum_q <= csum_q ^ rx_data_i;
`endif
            if (word_valid) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= inst_count_q[INST_SIZE-1:0];
              imem_wdata_q <= word;
              inst_count_q <= inst_count_d;
              if (inst_count_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                state_q     <= CSUM;
`else
                state_q     <= DONE;
                done_q      <= 1'b1;
                ack_valid_q <= 1'b1;
                ack_data_q  <= ack_byte(1'b1);
`endif
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CSUM: begin
            if (rx_valid_i) begin
              state_q     <= (rx_data_i == csum_q) ? DONE : ERR;
              done_q      <= (rx_data_i == csum_q);
              err_q       <= (rx_data_i != csum_q);
              ack_valid_q <= 1'b1;
              ack_data_q  <= ack_byte(rx_data_i == csum_q);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign busy_o       = (state_q == WAIT_AA) || (state_q == LEN) ||
                        (state_q == DATA)    || (state_q == CSUM);
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign inst_count_o = inst_count_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign ack_valid_o  = ack_valid_q;
  assign ack_data_o   = ack_data_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader; checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  localparam int INST_SIZE = 10;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 aa_sent;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ferr;
  logic                 imem_we;
  logic [INST_SIZE-1:0] imem_addr;
  logic [31:0]          imem_wdata;
  logic [INST_SIZE:0]   inst_count;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 ack_valid;
  logic [7:0]           ack_data;

  typedef struct packed {
    logic [INST_SIZE-1:0] addr;
    logic [31:0]          data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_ack[$];
  logic [7:0] xsum;
  int         n_checks;
  int         n_fail;

  instr_loader #(.INST_SIZE(INST_SIZE)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .aa_sent_i    (aa_sent),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ferr_i    (rx_ferr),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .inst_count_o (inst_count),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .ack_valid_o  (ack_valid),
    .ack_data_o   (ack_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every cycle advance goes through here so no write or ack pulse is missed.
  task automatic tick();
    wr_t        e;
    logic [7:0] a;
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", imem_addr, imem_wdata);
      end else begin
        e = exp_wr.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          n_fail++;
          $display("[TB] FAIL write: got addr %0d data %h, required addr %0d data %h", imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
    if (ack_valid === 1'b1) begin
      n_checks++;
      if (exp_ack.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_ack: got ack %h, required no ack", ack_data);
      end else begin
        a = exp_ack.pop_front();
        if (ack_data !== a) begin
          n_fail++;
          $display("[TB] FAIL ack_data: got %h, required %h", ack_data, a);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic ferr);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_ferr  = ferr;
    tick();
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 3; i >= 0; i--) applyStimulus(n[8*i +: 8], 1'b0);
  endtask

  task automatic send_word(input logic [INST_SIZE-1:0] addr, input logic [31:0] w);
    wr_t        e;
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      b    = w[8*i +: 8];
      xsum = xsum ^ b;
      if (i == 0) begin
        e.addr = addr;
        e.data = w;
        exp_wr.push_back(e);
      end
      applyStimulus(b, 1'b0);
    end
  endtask

  task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL pre_csum busy/done: got %b, required 10", {busy, done});
    end
    applyStimulus(xsum, 1'b0);
`endif
  endtask

  // A junk byte during WAIT_AA must be ignored, otherwise the length would shift.
  task automatic start_load();
    xsum    = 8'h00;
    start   = 1'b1;
    aa_sent = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wait_aa_busy: got %b, required 1", busy);
    end
    applyStimulus(8'hFF, 1'b0);
    aa_sent = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || inst_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL len_entry: got busy %b count %0d, required busy 1 count 0", busy, inst_count);
    end
  endtask

  task automatic end_load();
    start   = 1'b0;
    aa_sent = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, err} !== 3'b000 || inst_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_clear: got bde %b count %0d, required 000 count 0", {busy, done, err}, inst_count);
    end
    n_checks++;
    if (exp_wr.size() != 0 || exp_ack.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL missing_output: got %0d writes %0d acks outstanding, required 0 0", exp_wr.size(), exp_ack.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if ({imem_we, busy, done, err, ack_valid} !== 5'b0 || imem_addr !== '0 ||
        imem_wdata !== 32'h0 || inst_count !== '0 || ack_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got we%b b%b d%b e%b av%b addr %0d data %h cnt %0d ack %h, required all 0",
               imem_we, busy, done, err, ack_valid, imem_addr, imem_wdata, inst_count, ack_data);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_without_start: got busy %b, required 0", busy);
    end
    start_load();
    send_len(32'd2);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got busy %b, required 0", busy);
    end
    start   = 1'b0;
    aa_sent = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal_load();
    exp_ack.push_back(8'hAA);
    start_load();
    send_len(32'h0000_0002);
    send_word(0, 32'hDEADBEEF);
    send_word(1, 32'h01234567);
`ifndef LOADER_CHECKSUM_EN
    n_checks++;
    if (imem_we !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL last_write_with_done: got imem_we %b, required 1", imem_we);
    end
`endif
    send_csum();
    n_checks++;
    if ({done, err, ack_valid} !== 3'b101 || inst_count !== 11'd2) begin
      n_fail++;
      $display("[TB] FAIL normal_done: got dea %b count %0d, required 101 count 2", {done, err, ack_valid}, inst_count);
    end
    repeat (3) tick();
    n_checks++;
    if ({done, ack_valid} !== 2'b10 || inst_count !== 11'd2) begin
      n_fail++;
      $display("[TB] FAIL done_sticky: got done/ack %b count %0d, required 10 count 2", {done, ack_valid}, inst_count);
    end
    end_load();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    exp_ack.push_back(8'hAA);
    start_load();
    send_len(32'd6);
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      send_word(i[INST_SIZE-1:0], w);
    end
    send_csum();
    n_checks++;
    if (done !== 1'b1 || inst_count !== 11'd6) begin
      n_fail++;
      $display("[TB] FAIL b2b_done: got done %b count %0d, required 1 count 6", done, inst_count);
    end
    end_load();
  endtask

  task automatic test_empty();
    exp_ack.push_back(8'hAA);
    start_load();
    send_len(32'd0);
    send_csum();
    n_checks++;
    if ({done, err, ack_valid, imem_we} !== 4'b1010 || inst_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL empty_done: got dea_we %b count %0d, required 1010 count 0", {done, err, ack_valid, imem_we}, inst_count);
    end
    end_load();
  endtask

  task automatic test_oversize();
    exp_ack.push_back(8'h55);
    start_load();
    send_len((32'd1 << INST_SIZE) + 32'd1);
    n_checks++;
    if ({busy, done, err, ack_valid} !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL oversize_err: got bdea %b, required 0011", {busy, done, err, ack_valid});
    end
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    end_load();
    exp_ack.push_back(8'h55);
    start_load();
    send_len(32'h0100_0000);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL huge_len_err: got err %b, required 1", err);
    end
    end_load();
    start_load();
    send_len(32'd1 << INST_SIZE);
    n_checks++;
    if ({busy, err} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL max_len_accept: got busy/err %b, required 10", {busy, err});
    end
    send_word(0, 32'h0BADF00D);
    end_load();
  endtask

  task automatic test_framing_error();
    exp_ack.push_back(8'h55);
    start_load();
    send_len(32'd2);
    send_word(0, 32'h11223344);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b1);
    n_checks++;
    if ({err, ack_valid, imem_we} !== 3'b110 || inst_count !== 11'd1) begin
      n_fail++;
      $display("[TB] FAIL ferr_entry: got err_ack_we %b count %0d, required 110 count 1", {err, ack_valid, imem_we}, inst_count);
    end
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'hD0 + i), 1'b0);
    n_checks++;
    if (err !== 1'b1 || inst_count !== 11'd1) begin
      n_fail++;
      $display("[TB] FAIL ferr_sticky: got err %b count %0d, required 1 count 1", err, inst_count);
    end
    end_load();
  endtask

  task automatic test_abort_restart();
    start_load();
    send_len(32'd1);
    applyStimulus(8'hDE, 1'b0);
    applyStimulus(8'hAD, 1'b0);
    end_load();
    exp_ack.push_back(8'hAA);
    start_load();
    send_len(32'd1);
    send_word(0, 32'hCAFEF00D);
    send_csum();
    n_checks++;
    if (done !== 1'b1 || inst_count !== 11'd1) begin
      n_fail++;
      $display("[TB] FAIL restart_done: got done %b count %0d, required 1 count 1", done, inst_count);
    end
    end_load();
    // Drop start while the second write is already on the outputs.
    start_load();
    send_len(32'd3);
    send_word(0, 32'hA5A5_0001);
    send_word(1, 32'h5A5A_0002);
    start = 1'b0;
    tick();
    n_checks++;
    if ({imem_we, ack_valid, busy} !== 3'b000 || inst_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL abort_pending: got we_ack_busy %b count %0d, required 000 count 0", {imem_we, ack_valid, busy}, inst_count);
    end
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h70 + i), 1'b0);
    end_load();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    exp_ack.push_back(8'hAA);
    start_load();
    send_len(32'd1);
    send_word(0, 32'hDEADBEEF);
    applyStimulus(8'h22, 1'b0);
    n_checks++;
    if ({done, err, ack_valid} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL csum_match: got dea %b, required 101", {done, err, ack_valid});
    end
    end_load();
    exp_ack.push_back(8'h55);
    start_load();
    send_len(32'd1);
    send_word(0, 32'hDEADBEEF);
    applyStimulus(8'h23, 1'b0);
    n_checks++;
    if ({done, err, ack_valid} !== 3'b011 || inst_count !== 11'd1) begin
      n_fail++;
      $display("[TB] FAIL csum_mismatch: got dea %b count %0d, required 011 count 1", {done, err, ack_valid}, inst_count);
    end
    end_load();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    xsum     = 8'h00;
    rst      = 1'b1;
    start    = 1'b0;
    aa_sent  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    $display("[TB] instr_loader bench starting");
    test_reset();
    test_normal_load();
    test_back_to_back();
    test_empty();
    test_oversize();
    test_framing_error();
    test_abort_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
